// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared state encoding and default widths for the RAM port arbiter
package ram_port_arbiter_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DBG  = 1'b1
    } arb_state_t;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
endpackage

// File: rtl/ram_port_arbiter_wait_ctr.sv
// arb_wait_ctr: saturating up-counter with clear and a flag for the step that reaches LIMIT
module arb_wait_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TOP = W'(LIMIT);
    logic [W-1:0] cnt;
    assign hit = inc && cnt >= TOP - W'(1);
    // count up to LIMIT and stay there; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != TOP)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: core-priority sharing of one data RAM with a debug port and starvation-forced debug bursts
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arb_en,
    input  logic          core_req,
    input  logic          core_wen,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dbg_req,
    input  logic          dbg_wen,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out
);
    arb_state_t state, state_nx;
    logic en, core_acc, dbg_acc, wait_inc, wait_hit, burst_inc, burst_hit, dbg_rd_q;

    // outputs are held quiet while reset is asserted, not just after the flops clear
    assign en        = arb_en && reset_n;
    assign core_acc  = en && state == ST_IDLE && core_req;
    assign dbg_acc   = en && dbg_req && (state == ST_DBG || !core_req);
    assign wait_inc  = en && state == ST_IDLE && dbg_req && !dbg_acc;
    assign burst_inc = state == ST_DBG && dbg_acc;

    assign dbg_gnt    = dbg_acc;
    assign core_stall = reset_n && core_req && !core_acc;
    assign ram_cen    = core_acc || dbg_acc;
    assign dbg_rvalid = dbg_rd_q;
    assign dbg_rdata  = ram_out;
    assign core_rdata = ram_out;

    arb_wait_ctr #(.LIMIT(STARVE_LIMIT)) u_wait_cnt (
        .clk(clk), .reset_n(reset_n), .inc(wait_inc), .clr(!wait_inc), .hit(wait_hit)
    );
    arb_wait_ctr #(.LIMIT(MAX_BURST)) u_burst_cnt (
        .clk(clk), .reset_n(reset_n), .inc(burst_inc), .clr(!burst_inc), .hit(burst_hit)
    );

    // owner state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // next owner and RAM mux from whoever is accessing this cycle
    always_comb begin
        state_nx = !en ? ST_IDLE
                 : state == ST_IDLE ? (wait_hit ? ST_DBG : ST_IDLE)
                 : (!dbg_req || burst_hit) ? ST_IDLE : ST_DBG;
        ram_wen  = core_acc ? core_wen : dbg_acc && dbg_wen;
        ram_addr = core_acc ? core_addr : dbg_acc ? dbg_addr : '0;
        ram_data = core_acc ? core_wdata : dbg_acc ? dbg_wdata : '0;
    end

    // remember an accepted debug read so its data is flagged on the next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dbg_rd_q <= 1'b0;
        else
            dbg_rd_q <= dbg_acc && !dbg_wen;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int MB = 4;

    logic clk = 0, reset_n = 0, arb_en = 0;
    logic core_req = 0, core_wen = 0, dbg_req = 0, dbg_wen = 0;
    logic [AW-1:0] core_addr = 0, dbg_addr = 0;
    logic [DW-1:0] core_wdata = 0, dbg_wdata = 0;
    logic [DW-1:0] core_rdata, dbg_rdata, ram_data;
    logic [DW-1:0] ram_out = 0;
    logic [AW-1:0] ram_addr;
    logic core_stall, dbg_gnt, dbg_rvalid, ram_cen, ram_wen;

    int total = 0, bad = 0;
    logic [DW-1:0] mem[int];
    logic [DW-1:0] ref_mem[int];
    int waited = 0, burst = 0;
    bit forced = 0, exp_rv = 0, exp_cv = 0, last_gnt = 0;
    logic [DW-1:0] exp_rd = 0, exp_cd = 0;
    logic [13:0] gnt_trace;

    ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en),
        .core_req(core_req), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen)
                mem[int'(ram_addr)] = ram_data;
            else
                ram_out <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic model_reset();
        forced = 0; waited = 0; burst = 0; exp_rv = 0; exp_cv = 0;
    endtask

    task automatic cyc(input bit rst, input bit en, input bit cr, input bit cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bit core_acc, dbg_acc, stall;
        logic [AW+DW:0] exp_bus;
        @(negedge clk);
        reset_n = !rst; arb_en = en;
        core_req = cr; core_wen = cw; core_addr = ca; core_wdata = cd;
        dbg_req = dr; dbg_wen = dw; dbg_addr = da; dbg_wdata = dd;
        #2;
        chk("dbg_rvalid", 64'(dbg_rvalid), rst ? 64'd0 : 64'(exp_rv));
        if (exp_rv && !rst) chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_rd));
        if (exp_cv) chk("core_rdata", 64'(core_rdata), 64'(exp_cd));
        core_acc = !rst && en && !forced && cr;
        dbg_acc  = !rst && en && dr && (forced || !cr);
        stall    = !rst && cr && !core_acc;
        exp_bus  = core_acc ? {cw, ca, cd} : dbg_acc ? {dw, da, dd} : '0;
        chk("ram_cen", 64'(ram_cen), 64'(core_acc || dbg_acc));
        chk("dbg_gnt", 64'(dbg_gnt), 64'(dbg_acc));
        chk("core_stall", 64'(core_stall), 64'(stall));
        chk("ram_bus", 64'({ram_wen, ram_addr, ram_data}), 64'(exp_bus));
        last_gnt = dbg_gnt;
        exp_rv = dbg_acc && !dw; exp_rd = ref_rd(da);
        exp_cv = core_acc && !cw; exp_cd = ref_rd(ca);
        if (core_acc && cw) ref_mem[int'(ca)] = cd;
        if (dbg_acc && dw) ref_mem[int'(da)] = dd;
        if (rst || !en) begin
            forced = 0; waited = 0; burst = 0;
        end else if (forced) begin
            if (dbg_acc) burst++;
            if (!dr || burst == MB) begin forced = 0; burst = 0; end
        end else if (dr && !dbg_acc) begin
            waited++;
            if (waited == SL) begin forced = 1; waited = 0; burst = 0; end
        end else
            waited = 0;
    endtask

    task automatic both(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 16'h0100 + 16'(i), 0, 1, 0, 16'h0010, 0);
    endtask

    initial begin
        // reset held with every request high
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 16'h0001, 16'h1111, 1, 1, 16'h0002, 16'h2222);
        model_reset();
        // debug write then read with the core idle
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 16'h0010, 16'hBEEF);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 16'h0010, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_rdata", 64'(dbg_rdata), 64'h0000_0000_0000_BEEF);
        // both held: 8 core cycles, 4 forced debug grants, then core again
        for (int i = 0; i < 14; i++) begin
            cyc(0, 1, 1, 0, 16'h0200, 0, 1, 0, 16'h0010, 0);
            gnt_trace[i] = last_gnt;
        end
        chk("t3_pattern", 64'(gnt_trace), 64'h0000_0000_0000_0F00);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // forced burst cut short after two grants
        both(SL);
        both(2);
        cyc(0, 1, 1, 0, 16'h0300, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 16'h0300, 0, 0, 0, 0, 0);
        // core write then read back
        cyc(0, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 16'h0020, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rdata", 64'(core_rdata), 64'h0000_0000_0000_1234);
        // arb_en drop mid-burst keeps the pending read return
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        both(SL + 1);
        cyc(0, 0, 1, 0, 16'h0400, 0, 1, 0, 16'h0010, 0);
        cyc(0, 1, 1, 0, 16'h0400, 0, 1, 0, 16'h0010, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // asynchronous reset mid-burst drops the pending read
        both(SL + 1);
        #1 reset_n = 0;
        #1;
        chk("rst_ram_cen", 64'(ram_cen), 64'd0);
        chk("rst_dbg_gnt", 64'(dbg_gnt), 64'd0);
        chk("rst_core_stall", 64'(core_stall), 64'd0);
        @(negedge clk);
        #2 chk("rst_rvalid", 64'(dbg_rvalid), 64'd0);
        model_reset();
        cyc(0, 1, 1, 0, 16'h0500, 0, 1, 0, 16'h0010, 0);
        // random traffic over a small address window
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 15) != 0,
                $urandom_range(0, 2) != 0, 1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
